// File: rtl/stream_mux_rr_pkg.sv
// Shared constants and helpers for the stream_mux_rr round-robin stream multiplexer.
package stream_mux_rr_pkg;

  localparam int DATA_W = 8;
  localparam int CH_N   = 4;

  // Index width that never collapses to zero bits.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational arbiter for stream_mux_rr; rotating priority after ptr by default,
// fixed lowest-index priority when STREAM_MUX_FIXED_PRIO_EN is defined.
module rr_arbiter
  import stream_mux_rr_pkg::*;
#(
  parameter int N = CH_N,
  localparam int SELW = clog2_safe(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  input  logic            en,
  output logic [N-1:0]    gnt_onehot,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_any
);

  logic            found_s;
  logic [SELW-1:0] idx_s;

`ifdef STREAM_MUX_FIXED_PRIO_EN
  logic unused_ptr_s;
  assign unused_ptr_s = ^ptr;

  // Lowest-index requester wins.
  always_comb begin
    found_s = 1'b0;
    idx_s   = '0;
    for (int i = 0; i < N; i++) begin
      if (!found_s && req[i]) begin
        found_s = 1'b1;
        idx_s   = SELW'(i);
      end else begin
        found_s = found_s;
      end
    end
  end
`else
  // Search starts just after the last grant and wraps modulo N.
  always_comb begin
    found_s = 1'b0;
    idx_s   = '0;
    for (int i = 1; i <= N; i++) begin
      int cand;
      cand = (int'(ptr) + i) % N;
      if (!found_s && req[cand]) begin
        found_s = 1'b1;
        idx_s   = SELW'(cand);
      end else begin
        found_s = found_s;
      end
    end
  end
`endif

  assign gnt_any    = en & found_s;
  assign gnt_idx    = idx_s;
  assign gnt_onehot = gnt_any ? ({{(N-1){1'b0}}, 1'b1} << idx_s) : {N{1'b0}};

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with one output register stage.
// Define STREAM_MUX_FIXED_PRIO_EN for fixed priority (no pointer register).
module stream_mux_rr
  import stream_mux_rr_pkg::*;
#(
  parameter int W = DATA_W,
  parameter int N = CH_N,
  localparam int SELW = clog2_safe(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  output logic [W-1:0]    out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SELW-1:0] out_sel
);

  logic            load_s;
  logic            gnt_any_s;
  logic [N-1:0]    gnt_onehot_s;
  logic [SELW-1:0] gnt_idx_s;
  logic [SELW-1:0] ptr_s;

  logic [W-1:0]    data_q, data_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic            valid_q, valid_d;

  // Reset gates load so no input is accepted during the reset cycle.
  assign load_s = (~valid_q | out_ready) & ~reset;

`ifdef STREAM_MUX_FIXED_PRIO_EN
  assign ptr_s = '0;
`else
  logic [SELW-1:0] ptr_q, ptr_d;
  assign ptr_s = ptr_q;

  // Pointer tracks the most recent grant.
  always_comb begin
    if (gnt_any_s) begin
      ptr_d = gnt_idx_s;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register; N-1 after reset gives channel 0 first priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= SELW'(N - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  rr_arbiter #(.N(N)) u_arb (
    .req        (in_valid),
    .ptr        (ptr_s),
    .en         (load_s),
    .gnt_onehot (gnt_onehot_s),
    .gnt_idx    (gnt_idx_s),
    .gnt_any    (gnt_any_s)
  );

  assign in_ready = gnt_onehot_s;

  // Output stage next state: refill on a grant, empty on an idle load, else hold.
  always_comb begin
    data_d  = data_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    if (gnt_any_s) begin
      data_d  = in_data[int'(gnt_idx_s)*W +: W];
      sel_d   = gnt_idx_s;
      valid_d = 1'b1;
    end else if (load_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed self-checking bench for stream_mux_rr (N=4, W=8).
module tb_stream_mux_rr;

  logic        clk;
  logic        reset;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_sel;

  int total;
  int passed;
  int a5_cnt;

  stream_mux_rr #(.W(8), .N(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts accepted output words carrying 8'hA5.
  always @(posedge clk) begin
    if (!reset && out_valid && out_ready && out_data == 8'hA5) a5_cnt <= a5_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] s);
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, ".data"}, {24'd0, out_data}, {24'd0, d});
    chk({tag, ".sel"}, {30'd0, out_sel}, {30'd0, s});
  endtask

  initial begin
    logic [7:0] exp_d [5];
    logic [1:0] exp_s [5];
    logic [3:0] exp_r [5];
    total   = 0;
    passed  = 0;
    a5_cnt  = 0;
    reset     = 1'b1;
    in_data   = {8'h43, 8'h32, 8'h21, 8'h10};
    in_valid  = 4'b1111;
    out_ready = 1'b1;

    // Reset with everything valid.
    tick();
    tick();
    chk_out("rst", 1'b0, 8'h00, 2'd0);
    chk("rst.in_ready", {28'd0, in_ready}, 32'h0);
    reset = 1'b0;
    #1;
    chk("first.in_ready", {28'd0, in_ready}, 32'h1);

`ifdef STREAM_MUX_FIXED_PRIO_EN
    in_valid = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("fp.in_ready", {28'd0, in_ready}, 32'h2);
      tick();
      chk_out("fp", 1'b1, 8'h21, 2'd1);
    end
`else
    // Round-robin with all channels valid.
    exp_d = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
    exp_s = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_r = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out("rr", 1'b1, exp_d[i], exp_s[i]);
      chk("rr.in_ready", {28'd0, in_ready}, {28'd0, exp_r[i]});
    end

    // Backpressure with ch2 presenting A5.
    in_data  = {8'h43, 8'hA5, 8'h21, 8'h10};
    in_valid = 4'b0100;
    tick();
    chk_out("bp.load", 1'b1, 8'hA5, 2'd2);
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp.in_ready", {28'd0, in_ready}, 32'h0);
      tick();
      chk_out("bp.hold", 1'b1, 8'hA5, 2'd2);
    end
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    tick();
    chk_out("bp.drain", 1'b0, 8'hA5, 2'd2);
    chk("bp.once", a5_cnt, 32'd1);

    // Move pointer to 3, then sparse grants and wrap.
    in_data  = {8'h43, 8'h32, 8'h7E, 8'h10};
    in_valid = 4'b1000;
    tick();
    chk_out("ptr3", 1'b1, 8'h43, 2'd3);
    in_valid = 4'b0010;
    #1;
    chk("sparse.in_ready", {28'd0, in_ready}, 32'h2);
    tick();
    chk_out("sparse", 1'b1, 8'h7E, 2'd1);
    in_valid = 4'b0001;
    #1;
    chk("wrap.in_ready", {28'd0, in_ready}, 32'h1);
    tick();
    chk_out("wrap", 1'b1, 8'h10, 2'd0);

    // Idle: output empties, data holds.
    in_valid = 4'b0000;
    tick();
    chk_out("idle1", 1'b0, 8'h10, 2'd0);
    tick();
    chk_out("idle2", 1'b0, 8'h10, 2'd0);

    // Single requester granted every cycle.
    in_valid = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("single", 1'b1, 8'h32, 2'd2);
    end

    // Reset mid-stream drops the pending word and restores the pointer.
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    reset     = 1'b1;
    #1;
    chk("mrst.in_ready", {28'd0, in_ready}, 32'h0);
    tick();
    chk_out("mrst", 1'b0, 8'h00, 2'd0);
    reset     = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("mrst.first", {28'd0, in_ready}, 32'h1);
    tick();
    chk_out("mrst.out", 1'b1, 8'h10, 2'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-channel, W-bit multiplexer with a registered output and a valid/ready handshake on every channel.
- When several channels have data, a round-robin arbiter picks which one goes next.
- The output passes through one register stage and sustains full throughput.
- Used wherever several 8-bit producers share one consumer, e.g. several binary sources feeding a single binary-to-BCD converter.

Parameters:
- W, 8, data width per channel in bits (>=1).
- N, 4, number of input channels (>=2).
- SELW, $clog2(N), localparam: width of the channel index.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  N*W  flattened channel data; channel i occupies [i*W +: W].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; at most one bit set per cycle.
- out_data  output  W  registered selected data.
- out_valid  output  1  out_data holds an untaken word.
- out_ready  input  1  downstream accepts a word.
- out_sel  output  SELW  index of the channel that produced out_data.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_sel=0. Internal last-grant pointer = N-1, so channel 0 has first priority after reset.
- Load condition: load = !out_valid | out_ready.
- Arbitration (combinational):
  - Search in_valid starting at pointer+1 and wrap modulo N.
  - The first set bit is the grant g.
  - If no bit is set, there is no grant.
- Ready: in_ready[g] = load & (a grant exists); all other in_ready bits are 0.
- Input transfer on channel g: in_valid[g] & in_ready[g].
- On an input transfer at a clock edge:
  - out_data <= in_data[g*W +: W]
  - out_sel <= g
  - out_valid <= 1
  - pointer <= g
- Load with no grant: out_valid <= 0, out_data and out_sel hold their values, pointer holds.
- Stall (out_valid & !out_ready): out_data, out_sel, out_valid and pointer all hold. in_ready is all zero.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 word per cycle when out_ready stays high. A simultaneous drain and refill in the same cycle produces no bubble.
- Fairness: with all N channels continuously valid and out_ready=1, grants run in the order 0,1,…,N-1,0,…. No channel waits more than N-1 grants.
- Single requester: a lone valid channel is granted every cycle.
- Pointer wrap: when pointer=N-1 the search starts at channel 0.
- Producer obligation: in_data and in_valid stay stable while valid is high and ready is low. The block does not check this.
- Reset mid-stream: a pending out_valid word is dropped, the pointer returns to N-1, and in_ready is 0 during the reset cycle.

Optional Feature:
- Macro: STREAM_MUX_FIXED_PRIO_EN.
- Defined: the arbiter ignores the pointer and always grants the lowest-index valid channel (fixed priority). The pointer register is not built.
- Undefined: round-robin as specified above.
- Ports and latency are identical in both builds.

Decomposition:
- Shared package holds:
  - default width constant DATA_W=8;
  - default channel count CH_N=4;
  - a function clog2_safe returning at least 1.
- One sub-module: rr_arbiter.
  - Parameter N.
  - Inputs: req[N], ptr[SELW], en.
  - Outputs: gnt_onehot[N], gnt_idx[SELW], gnt_any.
  - Purely combinational; the macro selects fixed or rotating priority inside it.
- The top level holds the output register, the pointer and the handshake.

Test Plan:
- Reset: with in_valid=4'b1111 and out_ready=1 asserted during reset, out_valid=0 and out_data=0. The first grant after reset goes to channel 0, which requires in_ready=4'b0001.
- Round-robin: ch0..3 hold 8'h10, 8'h21, 8'h32, 8'h43, all valid, out_ready=1. out_data sequence is 10,21,32,43,10 on consecutive cycles with out_sel 0,1,2,3,0 and no bubble.
- Backpressure: out_ready=0 for 3 cycles after ch2 presents 8'hA5. out_data stays A5 and out_sel stays 2, in_ready stays 4'b0000. A5 appears exactly once after out_ready rises.
- Sparse/wrap: pointer=3, only ch1 valid (8'h7E). Grant goes to ch1. Then only ch0 valid: grant goes to ch0, proving the wrap.
- Idle: in_valid=0 with out_ready=1. out_valid drops to 0 one cycle after the last word is taken, and out_data keeps its last value.
- Fixed priority (macro defined): ch1 and ch3 valid continuously. ch1 wins every cycle and ch3 in_ready stays 0.
